rw_port_ram_arbiter: RTL and testbench

//  Shares one simple-dual-port RAM (rw_port_ram, 1 read + 1 write port, 1-cycle read latency)

---
 rtl/rw_port_ram_arbiter_pkg.sv | 20 ++
 rtl/rw_port_ram_arbiter_ram.sv | 34 +++
 rtl/rw_port_ram_arbiter_rr.sv | 48 ++++
 rtl/rw_port_ram_arbiter.sv | 102 ++++++++++
 tb/tb_rw_port_ram_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rw_port_ram_arbiter_pkg.sv
// Shared definitions for the arbitrated local-memory front end: id-width helper,
// arbiter search order and per-client packed-slice macro.
package rw_port_ram_arbiter_pkg;

  // Round-robin search walks upward from the pointer (1) or downward (0).
  localparam bit RR_SEARCH_UP = 1'b1;

  // clog2 with a floor of 1 so a pointer/id field never collapses to zero width.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`ifndef RPA_SLICE
`define RPA_SLICE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

// File: rtl/rw_port_ram_arbiter_ram.sv
// Simple dual-port RAM, one write and one registered read port, 1-cycle read latency.
// Read-during-write to the same address returns the old word. Contents are not reset.
module rw_port_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter string RAM_TYPE   = "auto"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (RAM_TYPE == "block") begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Write and registered read share one clock edge.
    always_ff @(posedge clk) begin
      if (we) mem[addr_w] <= data_in;
      data_out <= mem[addr_r];
    end
  end else begin : g_infer
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Write and registered read share one clock edge.
    always_ff @(posedge clk) begin
      if (we) mem[addr_w] <= data_in;
      data_out <= mem[addr_r];
    end
  end

endmodule

// File: rtl/rw_port_ram_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from the first request at or after ptr,
// pointer advances past the winner, holds when nothing is requested.
module rr_arbiter
  import rw_port_ram_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                gnt_any
);

  localparam int PW = clog2_min1(N_REQ);

  logic [PW-1:0] ptr;
  int            win;
  int            best_d;
  int            d;

  // Pick the requester with the smallest distance from ptr in search order.
  always_comb begin
    win    = 0;
    best_d = N_REQ;
    d      = 0;
    for (int j = 0; j < N_REQ; j++) begin
      if (RR_SEARCH_UP) d = (j + N_REQ - int'(ptr)) % N_REQ;
      else              d = (int'(ptr) + N_REQ - j) % N_REQ;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        win    = j;
      end
    end
    gnt_any = (best_d < N_REQ);
    for (int j = 0; j < N_REQ; j++) gnt[j] = gnt_any && (win == j);
    gnt_id = ID_WIDTH'(win);
  end

  // Pointer moves one past the winner, wrapping at N_REQ-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ptr <= '0;
    else if (gnt_any) ptr <= (win == N_REQ - 1) ? '0 : PW'(win + 1);
  end

endmodule

// File: rtl/rw_port_ram_arbiter.sv
// Shared local-memory front end: N_REQ readers and N_REQ writers share one
// simple-dual-port RAM through independent round-robin arbiters.
// Optional macro RW_PORT_RAM_ARBITER_FORWARD_EN: same-cycle read/write to the
// same address returns the newly written word instead of the RAM's old data.
module rw_port_ram_arbiter
  import rw_port_ram_arbiter_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    N_REQ      = 4,
  parameter int    ID_WIDTH   = 2,
  parameter string RAM_TYPE   = "auto"
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            rd_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_REQ-1:0]            rd_gnt,
  output logic                        rd_valid,
  output logic [ID_WIDTH-1:0]         rd_id,
  output logic [DATA_WIDTH-1:0]       rd_data,
  input  logic [N_REQ-1:0]            wr_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]            wr_gnt
);

  localparam int STAGES = 1;

  logic [N_REQ-1:0][ADDR_WIDTH-1:0] rd_addr_v;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] wr_addr_v;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] wr_data_v;

  logic [ID_WIDTH-1:0]   rd_gnt_id, wr_gnt_id;
  logic                  rd_fire, wr_fire;
  logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_w;
  logic [DATA_WIDTH-1:0] ram_din, ram_q;
  logic [STAGES:0]       vld_pipe;
  logic                  vld_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rd_addr_v[g] = `RPA_SLICE(rd_addr, g, ADDR_WIDTH);
    assign wr_addr_v[g] = `RPA_SLICE(wr_addr, g, ADDR_WIDTH);
    assign wr_data_v[g] = `RPA_SLICE(wr_data, g, DATA_WIDTH);
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_rd_arb (
    .clk(clk), .reset_n(reset_n), .req(rd_req),
    .gnt(rd_gnt), .gnt_id(rd_gnt_id), .gnt_any(rd_fire)
  );

  rr_arbiter #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_wr_arb (
    .clk(clk), .reset_n(reset_n), .req(wr_req),
    .gnt(wr_gnt), .gnt_id(wr_gnt_id), .gnt_any(wr_fire)
  );

  assign ram_addr_r = rd_addr_v[rd_gnt_id];
  assign ram_addr_w = wr_addr_v[wr_gnt_id];
  assign ram_din    = wr_data_v[wr_gnt_id];

  rw_port_ram #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RAM_TYPE(RAM_TYPE)
  ) u_ram (
    .clk(clk), .we(wr_fire), .addr_w(ram_addr_w), .data_in(ram_din),
    .addr_r(ram_addr_r), .data_out(ram_q)
  );

  // Read valid/id follow the grant by one cycle, aligned with the RAM output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      rd_id <= '0;
    end else begin
      vld_q <= rd_fire;
      if (rd_fire) rd_id <= rd_gnt_id;
    end
  end

  assign vld_pipe = {vld_q, rd_fire};
  assign rd_valid = vld_pipe[STAGES];

`ifdef RW_PORT_RAM_ARBITER_FORWARD_EN
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // Flag a read that collides with this cycle's write so the new word wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fwd_hit_q <= 1'b0;
    else          fwd_hit_q <= rd_fire && wr_fire && (ram_addr_r == ram_addr_w);
  end

  // Capture the write word alongside the flag; only consumed when the flag is set.
  always_ff @(posedge clk) begin
    fwd_data_q <= ram_din;
  end

  assign rd_data = fwd_hit_q ? fwd_data_q : ram_q;
`else
  assign rd_data = ram_q;
`endif

endmodule

// File: tb/tb_rw_port_ram_arbiter.sv
// Self-checking bench for rw_port_ram_arbiter: directed scenarios plus random
// traffic checked against a queue/array reference model of the arbitration rules.
module tb_rw_port_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic                 clk;
  logic                 reset_n;
  logic [N-1:0]         rd_req, wr_req;
  logic [N-1:0][AW-1:0] rd_addr, wr_addr;
  logic [N-1:0][DW-1:0] wr_data;
  logic [N-1:0]         rd_gnt, wr_gnt;
  logic                 rd_valid;
  logic [1:0]           rd_id;
  logic [DW-1:0]        rd_data;

  rw_port_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N), .ID_WIDTH(2), .RAM_TYPE("auto")
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            rptr, wptr;
  bit            exp_vld;
  int            exp_id;
  bit            exp_known;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] mem_m [int];
  int            last_rk, last_wk;

`ifdef RW_PORT_RAM_ARBITER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int ptr, input logic [N-1:0] req);
    for (int j = 0; j < N; j++) if (req[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int k);
    return (k < 0) ? 32'd0 : (32'd1 << k);
  endfunction

  // One clock cycle: check grants and last cycle's read result, advance the model.
  task automatic step();
    int rk, wk, a;
    #1;
    rk = winner(rptr, rd_req);
    wk = winner(wptr, wr_req);
    chk("rd_gnt", 32'(rd_gnt), onehot(rk));
    chk("wr_gnt", 32'(wr_gnt), onehot(wk));
    chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
    if (exp_vld) chk("rd_id", 32'(rd_id), exp_id);
    if (exp_vld && exp_known) chk("rd_data", rd_data, exp_data);
    last_rk = rk;
    last_wk = wk;
    if (rk >= 0) begin
      a         = int'(rd_addr[rk]);
      exp_known = mem_m.exists(a);
      exp_data  = exp_known ? mem_m[a] : 'x;
      if (FWD && wk >= 0 && int'(wr_addr[wk]) == a) begin
        exp_data  = wr_data[wk];
        exp_known = 1'b1;
      end
      exp_vld = 1'b1;
      exp_id  = rk;
      rptr    = (rk + 1) % N;
    end else begin
      exp_vld = 1'b0;
    end
    if (wk >= 0) begin
      mem_m[int'(wr_addr[wk])] = wr_data[wk];
      wptr = (wk + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    rptr = 0; wptr = 0; exp_vld = 1'b0;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int order [8];
    bit got3;
    int pool [8];
    reset_n = 1'b0;
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rptr = 0; wptr = 0; exp_vld = 1'b0; exp_id = 0; exp_known = 1'b0; exp_data = '0;
    last_rk = -1; last_wk = -1;

    // 1: reset with every request high
    rd_req = 4'b1111; wr_req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = AW'(5);
      wr_addr[i] = AW'(32 + i);
      wr_data[i] = 32'hA000_0000 + i;
    end
    @(posedge clk); #2;
    chk("t1_rd_valid", 32'(rd_valid), 32'd0);
    chk("t1_rd_id", 32'(rd_id), 32'd0);
    chk("t1_rd_gnt_in_reset", 32'(rd_gnt), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    chk("t1_first_grant", 32'(onehot(last_rk)), 32'b0001);

    // 2: write by client 2, read back by client 1
    rd_req = '0; wr_req = 4'b0100;
    wr_addr[2] = AW'(5); wr_data[2] = 32'hCAFE0002;
    step();
    chk("t2_wr_client", last_wk, 2);
    wr_req = '0; rd_req = 4'b0010; rd_addr[1] = AW'(5);
    step();
    rd_req = '0;
    step();
    chk("t2_id", 32'(rd_id), 32'd1);
    chk("t2_data", rd_data, 32'hCAFE0002);

    // 3: all readers held, strict rotation and back-to-back valid
    do_reset();
    for (int i = 0; i < N; i++) rd_addr[i] = AW'(5);
    rd_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      order[i] = last_rk;
    end
    rd_req = '0;
    for (int i = 0; i < 8; i++) chk("t3_order", order[i], i % N);
    step();

    // 4: same-cycle read and write to 0x10
    wr_req = 4'b0001; wr_addr[0] = AW'('h10); wr_data[0] = 32'h0;
    step();
    wr_req = 4'b0010; wr_addr[1] = AW'('h10); wr_data[1] = 32'h11111111;
    rd_req = 4'b0100; rd_addr[2] = AW'('h10);
    step();
    rd_req = '0; wr_req = '0;
    chk("t4_valid", 32'(rd_valid), 32'd1);
    chk("t4_data", rd_data, FWD ? 32'h11111111 : 32'h0);
    step();

    // 5: client 3 holds while 0/1 toggle
    got3 = 1'b0;
    rd_addr[3] = AW'(5);
    for (int i = 0; i < N && !got3; i++) begin
      rd_req = {1'b1, 1'b0, 2'($urandom_range(0, 3))};
      step();
      if (last_rk == 3) got3 = 1'b1;
    end
    chk("t5_client3_within_4", 32'(got3), 32'd1);
    rd_req = '0;
    step();

    // 6: reset between grant and rd_valid
    rd_req = 4'b0100; rd_addr[2] = AW'(5);
    step();
    chk("t6_valid_before", 32'(rd_valid), 32'd1);
    rd_req = '0;
    do_reset();
    rd_req = 4'b1001;
    step();
    chk("t6_ptr_zero", last_rk, 0);
    rd_req = '0;
    step();

    // Random traffic over a small address pool including the top address.
    for (int i = 0; i < 7; i++) pool[i] = i;
    pool[7] = (1 << AW) - 1;
    for (int i = 0; i < 8; i++) begin
      wr_req = 4'b0001; wr_addr[0] = AW'(pool[i]); wr_data[0] = $urandom;
      step();
    end
    wr_req = '0;
    for (int c = 0; c < 300; c++) begin
      rd_req = 4'($urandom_range(0, 15));
      wr_req = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        rd_addr[i] = AW'(pool[$urandom_range(0, 7)]);
        wr_addr[i] = AW'(pool[$urandom_range(0, 7)]);
        wr_data[i] = $urandom;
      end
      step();
    end
    rd_req = '0; wr_req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
